// File: rtl/vga_sync_gen_if.sv
// Timing bundle produced by vga_sync_gen and consumed by the pixel/game logic.
interface vga_sync_gen_if;
  logic       p_tick;
  logic [9:0] x;
  logic [9:0] y;
  logic       video_on;
  logic       hsync;
  logic       vsync;
  logic       frame_end;

  modport master (
    output p_tick, x, y, video_on, hsync, vsync, frame_end
  );

  modport slave (
    input p_tick, x, y, video_on, hsync, vsync, frame_end
  );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA timing generator: divides the system clock down to the pixel rate,
// walks the raster position and produces skew-free registered sync pulses.
module vga_sync_gen #(
  parameter int TICK_DIV  = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic           clk_100MHz,
  input  logic           reset_n,
  vga_sync_gen_if.master vga
);

  localparam int H_TOTAL      = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL      = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_DISPLAY + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;
  localparam int DIV_W        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  // Half-open window test [lo, hi) used for both sync pulses.
  function automatic logic in_window(input logic [9:0] pos,
                                     input logic [9:0] lo,
                                     input logic [9:0] hi);
    return (pos >= lo) && (pos < hi);
  endfunction

  logic [DIV_W-1:0] div_r;
  logic [9:0]       h_cnt_r;
  logic [9:0]       v_cnt_r;
  logic [9:0]       h_next_s;
  logic [9:0]       v_next_s;
  logic             hsync_r;
  logic             vsync_r;
  logic             p_tick_s;
  logic             h_last_s;
  logic             v_last_s;

  // The tick is a pure decode of the divider register, so it is glitch-free.
  assign p_tick_s = (div_r == DIV_W'(TICK_DIV - 1));
  assign h_last_s = (h_cnt_r == 10'(H_TOTAL - 1));
  assign v_last_s = (v_cnt_r == 10'(V_TOTAL - 1));

  // Next raster position; the vertical count only moves at the end of a line.
  always_comb begin
    h_next_s = h_cnt_r;
    v_next_s = v_cnt_r;
    if (h_last_s) begin
      h_next_s = 10'd0;
      if (v_last_s) begin
        v_next_s = 10'd0;
      end else begin
        v_next_s = v_cnt_r + 10'd1;
      end
    end else begin
      h_next_s = h_cnt_r + 10'd1;
      v_next_s = v_cnt_r;
    end
  end

  // Pixel-rate divider: counts 0..TICK_DIV-1 and restarts on the tick.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      div_r <= '0;
    end else if (p_tick_s) begin
      div_r <= '0;
    end else begin
      div_r <= div_r + DIV_W'(1);
    end
  end

  // Raster counters and syncs; syncs are computed from the next position so
  // they update on the same edge as x/y and never lag them by a pixel.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt_r <= 10'd0;
      v_cnt_r <= 10'd0;
      hsync_r <= 1'b1;
      vsync_r <= 1'b1;
    end else if (p_tick_s) begin
      h_cnt_r <= h_next_s;
      v_cnt_r <= v_next_s;
      hsync_r <= ~in_window(h_next_s, 10'(H_SYNC_START), 10'(H_SYNC_END));
      vsync_r <= ~in_window(v_next_s, 10'(V_SYNC_START), 10'(V_SYNC_END));
    end
  end

  assign vga.p_tick    = p_tick_s;
  assign vga.x         = h_cnt_r;
  assign vga.y         = v_cnt_r;
  assign vga.video_on  = (h_cnt_r < 10'(H_DISPLAY)) && (v_cnt_r < 10'(V_DISPLAY));
  assign vga.hsync     = hsync_r;
  assign vga.vsync     = vsync_r;
  assign vga.frame_end = p_tick_s && h_last_s && v_last_s;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a full-size instance (TICK_DIV=4) for line timing and
// a shrunken TICK_DIV=2 instance for frame wrap, vsync and mid-frame reset.
// Expected pixels are queued per instance; monitors pop them on p_tick.
module tb_vga_sync_gen;

  typedef struct {
    int       k;     // tick number since reset release (1-based)
    int       cyc;   // clk cycle number of that tick since release
    int       x;
    int       y;
    int       flags; // {hsync, vsync, video_on, frame_end}
  } exp_t;

  logic clk = 1'b0;
  logic rst_a_n = 1'b0;
  logic rst_b_n = 1'b0;

  int n_pass = 0;
  int n_chk  = 0;

  exp_t qa[$];
  exp_t qb[$];

  int cyc_a = 0, tick_a = 0, bad_tick_a = 0, hs_low_a = 0, fe_a = 0;
  int cyc_b = 0, tick_b = 0, bad_tick_b = 0, fe_b = 0, fe_stray_b = 0;

  always #5 clk = ~clk;

  vga_sync_gen_if ifa ();
  vga_sync_gen_if ifb ();

  vga_sync_gen dut_a (
    .clk_100MHz (clk),
    .reset_n    (rst_a_n),
    .vga        (ifa)
  );

  vga_sync_gen #(
    .TICK_DIV(2), .H_DISPLAY(10), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) dut_b (
    .clk_100MHz (clk),
    .reset_n    (rst_b_n),
    .vga        (ifb)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic exp_t mk(input int k, input int div, input int x,
                              input int y, input int flags);
    exp_t e;
    e.k = k; e.cyc = k * div; e.x = x; e.y = y; e.flags = flags;
    return e;
  endfunction

  task automatic chk_reset(input string tag, input logic [9:0] x,
                           input logic [9:0] y, input logic hs, input logic vs,
                           input logic pt, input logic fe, input logic von);
    chk({tag, " x"}, int'(x), 0);
    chk({tag, " y"}, int'(y), 0);
    chk({tag, " {hs,vs,pt,fe,von}"}, int'({hs, vs, pt, fe, von}), int'(5'b11001));
  endtask

  task automatic cmp(input string tag, input exp_t e, input int cyc,
                     input logic [9:0] x, input logic [9:0] y,
                     input logic hs, input logic vs, input logic von,
                     input logic fe);
    chk($sformatf("%s k=%0d cycle", tag, e.k), cyc, e.cyc);
    chk($sformatf("%s k=%0d x", tag, e.k), int'(x), e.x);
    chk($sformatf("%s k=%0d y", tag, e.k), int'(y), e.y);
    chk($sformatf("%s k=%0d {hs,vs,von,fe}", tag, e.k),
        int'({hs, vs, von, fe}), e.flags);
  endtask

  // Monitor for the full-size instance.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_a_n) begin
        cyc_a = 0; tick_a = 0;
      end else begin
        cyc_a++;
        if (ifa.p_tick !== ((cyc_a % 4) == 0)) bad_tick_a++;
        if (tick_a < 1601 && ifa.hsync === 1'b0) hs_low_a++;
        if (ifa.frame_end === 1'b1) fe_a++;
        if (ifa.p_tick === 1'b1) begin
          tick_a++;
          if (qa.size() > 0 && qa[0].k == tick_a) begin
            e = qa.pop_front();
            cmp("A", e, cyc_a, ifa.x, ifa.y, ifa.hsync, ifa.vsync,
                ifa.video_on, ifa.frame_end);
          end
        end
      end
    end
  end

  // Monitor for the shrunken instance.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_b_n) begin
        cyc_b = 0; tick_b = 0;
      end else begin
        cyc_b++;
        if (ifb.p_tick !== ((cyc_b % 2) == 0)) bad_tick_b++;
        if (ifb.frame_end === 1'b1) begin
          fe_b++;
          if (ifb.p_tick !== 1'b1) fe_stray_b++;
        end
        if (ifb.p_tick === 1'b1) begin
          tick_b++;
          if (qb.size() > 0 && qb[0].k == tick_b) begin
            e = qb.pop_front();
            cmp("B", e, cyc_b, ifb.x, ifb.y, ifb.hsync, ifb.vsync,
                ifb.video_on, ifb.frame_end);
          end
        end
      end
    end
  end

  // Stimulus for the full-size instance: reset, then two complete lines.
  task automatic run_a();
    repeat (10) @(negedge clk);
    chk_reset("A reset", ifa.x, ifa.y, ifa.hsync, ifa.vsync, ifa.p_tick,
              ifa.frame_end, ifa.video_on);
    qa.push_back(mk(1,    4, 0,   0, 4'b1110));
    qa.push_back(mk(2,    4, 1,   0, 4'b1110));
    qa.push_back(mk(640,  4, 639, 0, 4'b1110));
    qa.push_back(mk(641,  4, 640, 0, 4'b1100));
    qa.push_back(mk(656,  4, 655, 0, 4'b1100));
    qa.push_back(mk(657,  4, 656, 0, 4'b0100));
    qa.push_back(mk(752,  4, 751, 0, 4'b0100));
    qa.push_back(mk(753,  4, 752, 0, 4'b1100));
    qa.push_back(mk(800,  4, 799, 0, 4'b1100));
    qa.push_back(mk(801,  4, 0,   1, 4'b1110));
    qa.push_back(mk(1600, 4, 799, 1, 4'b1100));
    qa.push_back(mk(1601, 4, 0,   2, 4'b1110));
    @(posedge clk); #1 rst_a_n = 1'b1;
    for (int i = 0; i < 7000 && qa.size() != 0; i++) @(negedge clk);
    chk("A vectors drained", qa.size(), 0);
    chk("A hsync low clks over two lines", hs_low_a, 768);
    chk("A p_tick period violations", bad_tick_a, 0);
    chk("A frame_end pulses", fe_a, 0);
  endtask

  // Stimulus for the shrunken instance: two frames, mid-frame reset, restart.
  task automatic run_b();
    repeat (10) @(negedge clk);
    chk_reset("B reset", ifb.x, ifb.y, ifb.hsync, ifb.vsync, ifb.p_tick,
              ifb.frame_end, ifb.video_on);
    qb.push_back(mk(1,   2, 0,  0, 4'b1110));
    qb.push_back(mk(10,  2, 9,  0, 4'b1110));
    qb.push_back(mk(11,  2, 10, 0, 4'b1100));
    qb.push_back(mk(12,  2, 11, 0, 4'b1100));
    qb.push_back(mk(13,  2, 12, 0, 4'b0100));
    qb.push_back(mk(15,  2, 14, 0, 4'b0100));
    qb.push_back(mk(16,  2, 15, 0, 4'b1100));
    qb.push_back(mk(102, 2, 16, 5, 4'b1100));
    qb.push_back(mk(103, 2, 0,  6, 4'b1100));
    qb.push_back(mk(120, 2, 0,  7, 4'b1000));
    qb.push_back(mk(133, 2, 13, 7, 4'b0000));
    qb.push_back(mk(137, 2, 0,  8, 4'b1000));
    qb.push_back(mk(154, 2, 0,  9, 4'b1100));
    qb.push_back(mk(170, 2, 16, 9, 4'b1101));
    qb.push_back(mk(171, 2, 0,  0, 4'b1110));
    qb.push_back(mk(340, 2, 16, 9, 4'b1101));
    qb.push_back(mk(341, 2, 0,  0, 4'b1110));
    qb.push_back(mk(490, 2, 13, 8, 4'b0000));
    @(posedge clk); #1 rst_b_n = 1'b1;
    for (int i = 0; i < 1200 && tick_b < 490; i++) begin
      @(negedge clk); #1;
    end
    chk("B reached mid-frame point", tick_b, 490);
    chk("B vectors drained", qb.size(), 0);
    chk("B frame_end pulses", fe_b, 2);
    // Both syncs are low here; reset must release them at once.
    rst_b_n = 1'b0;
    #1;
    chk_reset("B mid-frame reset", ifb.x, ifb.y, ifb.hsync, ifb.vsync,
              ifb.p_tick, ifb.frame_end, ifb.video_on);
    repeat (10) @(negedge clk);
    qb.push_back(mk(1,  2, 0,  0, 4'b1110));
    qb.push_back(mk(2,  2, 1,  0, 4'b1110));
    qb.push_back(mk(17, 2, 16, 0, 4'b1100));
    qb.push_back(mk(18, 2, 0,  1, 4'b1110));
    @(posedge clk); #1 rst_b_n = 1'b1;
    for (int i = 0; i < 200 && qb.size() != 0; i++) @(negedge clk);
    chk("B restart vectors drained", qb.size(), 0);
    chk("B p_tick period violations", bad_tick_b, 0);
    chk("B frame_end outside p_tick", fe_stray_b, 0);
  endtask

  initial begin
    fork
      run_a();
      run_b();
    join
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed",
             n_pass, n_chk);
    $fatal(1);
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Generates 640x480 @ 60 Hz VGA timing from the 100 MHz board clock. Supplies the current pixel coordinate, the display-active flag and the horizontal and vertical sync pulses. The pixel generation logic consumes these to produce the rgb value for each pixel. Also provides a pixel-rate tick and an end-of-frame strobe, which the game and object-movement logic uses to update once per frame.

## Interface
Parameters:
- TICK_DIV, 4: clk cycles per pixel (100 MHz / 4 = 25 MHz pixel rate)
- H_DISPLAY, 640: visible pixels per line
- H_FRONT, 16: horizontal front porch, in pixels
- H_SYNC, 96: hsync pulse width, in pixels
- H_BACK, 48: horizontal back porch, in pixels
- V_DISPLAY, 480: visible lines per frame
- V_FRONT, 10: vertical front porch, in lines
- V_SYNC, 2: vsync pulse width, in lines
- V_BACK, 33: vertical back porch, in lines

Ports:
- clk_100MHz  in  1: system clock
- reset_n  in  1: asynchronous, active-low reset
- p_tick  out  1: one clk-cycle pulse per pixel period
- x  out  10: current horizontal count, 0..H_TOTAL-1
- y  out  10: current vertical count, 0..V_TOTAL-1
- video_on  out  1: high when x < H_DISPLAY and y < V_DISPLAY
- hsync  out  1: horizontal sync, active low
- vsync  out  1: vertical sync, active low
- frame_end  out  1: one clk-cycle pulse on the last pixel of a frame

## Operation
- Derived constants:
  - H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK = 800
  - V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK = 525
- Pixel divider: a mod-TICK_DIV counter `div`. p_tick = (div == TICK_DIV-1), decoded from the register.
- Horizontal counter h_cnt:
  - Advances only on clk edges where p_tick = 1.
  - Wraps from H_TOTAL-1 to 0.
- Vertical counter v_cnt:
  - Advances only on a p_tick edge where h_cnt == H_TOTAL-1.
  - Wraps from V_TOTAL-1 to 0.
- Outputs:
  - x = h_cnt, y = v_cnt.
  - video_on is a combinational decode of h_cnt and v_cnt.
- hsync and vsync are registered and computed from the next-state counter values, so they change on the same edge as x and y, with no skew and no glitches.
  - hsync = 0 iff H_DISPLAY+H_FRONT <= x < H_DISPLAY+H_FRONT+H_SYNC, i.e. x in 656..751.
  - vsync = 0 iff V_DISPLAY+V_FRONT <= y < V_DISPLAY+V_FRONT+V_SYNC, i.e. y in 490..491.
- frame_end = p_tick && h_cnt == H_TOTAL-1 && v_cnt == V_TOTAL-1.
- Counter widths are 10 bits; all comparisons are unsigned. Counts are never allowed to reach or exceed H_TOTAL or V_TOTAL.

## Timing
- Reset values while reset_n = 0, applied immediately (asynchronous):
  - div = 0, x = 0, y = 0
  - hsync = 1, vsync = 1
  - p_tick = 0, frame_end = 0
  - video_on = 1 (decoded from position (0,0))
- Reset release: div counts 0, 1, 2, 3. p_tick is first high during the 4th clk cycle after release, and x becomes 1 on the edge that ends that cycle.
- Pixel period: exactly TICK_DIV clks. x, y, hsync and vsync hold for all TICK_DIV cycles of a pixel.
- Line period: H_TOTAL × TICK_DIV = 3200 clks.
- Frame period: V_TOTAL × 3200 = 1,680,000 clks (59.52 Hz).
- Line wrap: x: 799 → 0 and y: n → n+1 change on the same edge.
- Frame wrap: on the frame_end edge, both x and y return to 0, and vsync/hsync take their values for (0,0), both high.
- Reset asserted mid-line or mid-frame: all state clears at once. No partial sync pulse may remain asserted.
- Latency: the rgb produced from (x, y, video_on) is combinational and aligns with hsync/vsync. No pipeline compensation is required downstream.

## Test plan
- Reset: hold reset_n = 0 for 10 clks -> x = 0, y = 0, hsync = 1, vsync = 1, p_tick = 0, frame_end = 0. Release -> p_tick pulses at clks 4, 8, 12, ..., exactly 1 cycle wide each.
- Horizontal: over one line, hsync goes low on the edge where x becomes 656 and returns high where x becomes 752 (384 clks low). Line repeats every 3200 clks. video_on falls when x goes 639 → 640.
- Vertical: vsync is low for y = 490..491 (6400 clks). video_on is 0 for all x while y >= 480. y wraps 524 → 0.
- Frame: frame_end pulses exactly once per 1,680,000 clks, 1 clk wide, coincident with p_tick at (799, 524). The next edge gives x = 0, y = 0.
- Mid-frame reset: assert reset_n = 0 at (700, 491), with hsync and vsync both low -> both go high immediately and counters read 0. After release, timing restarts exactly as in the reset scenario.
- Parameter override: TICK_DIV = 2 -> p_tick every 2 clks and line period 1600 clks; all pixel-count boundaries are unchanged.
